alu_shift_sequencer: RTL and testbench
======================================

Name: alu_shift_sequencer

Overview:
- Multi-cycle controller that sequences shift and rotate operations on a 32-bit operand, STEP bits per clock.
- Replaces a full single-cycle barrel shifter in the ALU path with a small iterative shifter plus FSM.
- Sits beside the ALU.
- The control unit issues a start with opcode, operand and amount, then waits for done before latching result into Z.

Parameters:
- STEP, 4, bits shifted per iteration cycle. Legal values: 1, 2, 4, 8, 16.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled on a rising edge when the FSM is not in SHIFT.
- op  input  3  operation code: 000 SHR (logical right), 001 SHRA (arithmetic right), 010 SHL, 011 ROR, 100 ROL; 101–111 illegal.
- A  input  32  operand.
- amount  input  32  shift/rotate count; only amount[4:0] is used (count mod 32).
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse: result is valid.
- result  output  32  final value; held until the next accepted start completes.

Behaviour:
- Reset (clear=1 at an edge): state=IDLE, busy=0, done=0, result=0, internal work register=0, remaining count=0. Clear overrides start and aborts any operation in progress; no done is produced for the aborted operation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at edge k:
  - Latch op, work=A, rem=amount[4:0].
  - Illegal op forces rem=0 (pass-through: result=A).
  - Go to SHIFT.
- IDLE or DONE with start=0: go to IDLE.
- SHIFT, rem!=0: apply one step of s=min(rem,STEP) bits to work, rem=rem-s, stay in SHIFT.
  - SHR: zero fill.
  - SHRA: sign-bit fill from work[31].
  - SHL: zero fill.
  - ROR/ROL: bits wrap around.
- SHIFT, rem==0: result=work, go to DONE.
- DONE: done=1 for exactly that one cycle.
- start while in SHIFT is ignored; it is not queued.
- Latency: with n=ceil(amount[4:0]/STEP), the shift edges are k+1..k+n. Result and done become visible after edge k+n+1. For amount 0, done follows edge k+1.
- Back-to-back: start accepted in DONE. Done is still high that cycle; the next operation begins with no IDLE bubble.
- result changes only on the SHIFT→DONE edge. The operand A and amount may change freely after edge k.
- busy=1 exactly while state==SHIFT. done=1 exactly while state==DONE. Both are registered and glitch-free.
- Arithmetic:
  - Rotation by 0 or any multiple of 32 returns A unchanged.
  - Count width is 5 bits, so rem never exceeds 31.
  - Partial last step uses rem<STEP bits.

Test Plan:
- STEP=4, op=ROR, A=0x8000_0001, amount=4, start at edge k -> busy high for 2 cycles; done pulses after edge k+2; result=0x1800_0000.
- op=SHRA, A=0x8000_0000, amount=31 -> n=8; done after edge k+9; result=0xFFFF_FFFF. Same stimulus with op=SHR -> result=0x0000_0001.
- op=SHL, A=0x0000_0001, amount=0x0000_003F (uses 31) -> result=0x8000_0000. op=ROL, A=0x1234_5678, amount=8 -> result=0x3456_7812.
- amount=0 with op=ROR, A=0xDEAD_BEEF, and illegal op=111 with amount=5 -> both give done after edge k+1 and result=0xDEAD_BEEF.
- start pulsed again mid-SHIFT with different A -> ignored; original result produced. Start asserted during the DONE cycle -> new op runs immediately; done pulses for each.
- clear asserted during SHIFT of a 31-bit SHL -> next cycle busy=0, done=0, result=0; no done pulse follows. A subsequent start works normally.

Source files
------------

// File: rtl/alu_shift_sequencer_if.sv
// Control-unit <-> shift sequencer handshake: request fields in, status and result out.
interface alu_shift_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] amount;
    logic        busy;
    logic        done;
    logic [31:0] result;

    // The control unit drives requests and waits on done.
    modport master (
        output start,
        output op,
        output A,
        output amount,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  A,
        input  amount,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Iterative shift/rotate unit: moves up to STEP bits per clock instead of a full
// single-cycle barrel shifter, then presents the value with a one-cycle done pulse.
module alu_shift_sequencer #(
    parameter int unsigned STEP = 4
) (
    input logic                  clock,
    input logic                  clear,
    alu_shift_sequencer_if.slave bus
);

    localparam logic [2:0] OpShr  = 3'b000;
    localparam logic [2:0] OpShra = 3'b001;
    localparam logic [2:0] OpShl  = 3'b010;
    localparam logic [2:0] OpRor  = 3'b011;
    localparam logic [2:0] OpRol  = 3'b100;

    localparam logic [4:0] StepW = 5'(STEP);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } stateT;

    stateT       stateQ, stateD;
    logic [2:0]  opQ, opD;
    logic [31:0] workQ, workD;
    logic [4:0]  remQ, remD;
    logic [31:0] resultQ, resultD;
    logic        busyQ;
    logic        doneQ;

    logic [4:0]  stepAmt;
    logic [31:0] shifted;
    logic [63:0] rotRight;
    logic [63:0] rotLeft;
    logic        opLegal;

    // Only the count mod 32 matters.
    logic unusedAmountHi;
    assign unusedAmountHi = ^bus.amount[31:5];

    assign opLegal = (bus.op <= OpRol);

    // One iteration: shift by min(rem, STEP); the final step may be partial.
    always_comb begin
        stepAmt  = (remQ < StepW) ? remQ : StepW;
        rotRight = {workQ, workQ} >> stepAmt;
        rotLeft  = {workQ, workQ} << stepAmt;
        shifted  = workQ;
        case (opQ)
            OpShr:   shifted = workQ >> stepAmt;
            OpShra:  shifted = $unsigned($signed(workQ) >>> stepAmt);
            OpShl:   shifted = workQ << stepAmt;
            OpRor:   shifted = rotRight[31:0];
            OpRol:   shifted = rotLeft[63:32];
            default: shifted = workQ;
        endcase
    end

    always_comb begin
        stateD  = stateQ;
        opD     = opQ;
        workD   = workQ;
        remD    = remQ;
        resultD = resultQ;
        case (stateQ)
            StIdle, StDone: begin
                if (bus.start) begin
                    opD    = bus.op;
                    workD  = bus.A;
                    // Illegal opcodes pass the operand straight through.
                    remD   = opLegal ? bus.amount[4:0] : 5'd0;
                    stateD = StShift;
                end else begin
                    stateD = StIdle;
                end
            end
            StShift: begin
                if (remQ != 5'd0) begin
                    workD = shifted;
                    remD  = remQ - stepAmt;
                end else begin
                    resultD = workQ;
                    stateD  = StDone;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            stateQ  <= StIdle;
            opQ     <= OpShr;
            workQ   <= 32'd0;
            remQ    <= 5'd0;
            resultQ <= 32'd0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            opQ     <= opD;
            workQ   <= workD;
            remQ    <= remD;
            resultQ <= resultD;
            // Status flags are flops of the next state so they never glitch.
            busyQ   <= (stateD == StShift);
            doneQ   <= (stateD == StDone);
        end
    end

    assign bus.busy   = busyQ;
    assign bus.done   = doneQ;
    assign bus.result = resultQ;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with STEP=4: latency, results, overlap and clear.
module tb_alu_shift_sequencer;

    logic clock = 1'b0;
    logic clear;
    int   nCompared = 0;
    int   nMismatch = 0;

    always #5 clock = ~clock;

    alu_shift_sequencer_if bus ();

    alu_shift_sequencer #(
        .STEP(4)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus.slave)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one start, then wait (bounded) for done. expEdges counts edges after the accept edge.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] amt, input logic [31:0] expRes, input int expEdges);
        int edges = 0;
        int busyCycles = 0;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.A      = a;
        bus.amount = amt;
        tick();
        bus.start  = 1'b0;
        bus.op     = 3'b010;
        bus.A      = ~a;
        bus.amount = 32'd5;
        checkVal({tag, ":busyAfterStart"}, 32'(bus.busy), 32'd1);
        checkVal({tag, ":noEarlyDone"}, 32'(bus.done), 32'd0);
        while (!bus.done && edges < 64) begin
            if (bus.busy) busyCycles++;
            tick();
            edges++;
        end
        checkVal({tag, ":doneSeen"}, 32'(bus.done), 32'd1);
        checkVal({tag, ":latency"}, 32'(edges), 32'(expEdges));
        checkVal({tag, ":busyCycles"}, 32'(busyCycles), 32'(expEdges));
        checkVal({tag, ":busyLowInDone"}, 32'(bus.busy), 32'd0);
        checkVal({tag, ":result"}, bus.result, expRes);
    endtask

    task automatic idleCheck(input string tag, input logic [31:0] expRes);
        tick();
        checkVal({tag, ":donePulseEnds"}, 32'(bus.done), 32'd0);
        checkVal({tag, ":idleNotBusy"}, 32'(bus.busy), 32'd0);
        checkVal({tag, ":resultHeld"}, bus.result, expRes);
    endtask

    initial begin
        int edges;
        int doneSeen;
        clear      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.A      = 32'd0;
        bus.amount = 32'd0;
        tick();
        tick();
        checkVal("reset:busy", 32'(bus.busy), 32'd0);
        checkVal("reset:done", 32'(bus.done), 32'd0);
        checkVal("reset:result", bus.result, 32'd0);
        clear = 1'b0;
        tick();

        runOp("ror4", 3'b011, 32'h8000_0001, 32'd4, 32'h1800_0000, 2);
        idleCheck("ror4", 32'h1800_0000);
        runOp("shra31", 3'b001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9);
        idleCheck("shra31", 32'hFFFF_FFFF);
        runOp("shr31", 3'b000, 32'h8000_0000, 32'd31, 32'h0000_0001, 9);
        idleCheck("shr31", 32'h0000_0001);
        runOp("shl63", 3'b010, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 9);
        idleCheck("shl63", 32'h8000_0000);
        runOp("rol8", 3'b100, 32'h1234_5678, 32'd8, 32'h3456_7812, 3);
        idleCheck("rol8", 32'h3456_7812);
        runOp("illegal", 3'b111, 32'hDEAD_BEEF, 32'd5, 32'hDEAD_BEEF, 1);
        idleCheck("illegal", 32'hDEAD_BEEF);
        runOp("shrPartial", 3'b000, 32'hF000_0000, 32'd6, 32'h03C0_0000, 3);
        idleCheck("shrPartial", 32'h03C0_0000);
        runOp("ror0", 3'b011, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
        idleCheck("ror0", 32'hDEAD_BEEF);
        runOp("ror32", 3'b011, 32'h0F0F_1234, 32'd32, 32'h0F0F_1234, 1);
        idleCheck("ror32", 32'h0F0F_1234);

        // Back-to-back: second start lands in the DONE cycle of the first.
        runOp("b2bFirst", 3'b100, 32'h1234_5678, 32'd8, 32'h3456_7812, 3);
        runOp("b2bSecond", 3'b000, 32'h8000_0000, 32'd4, 32'h0800_0000, 2);
        idleCheck("b2bSecond", 32'h0800_0000);

        // Start pulses during SHIFT must be ignored and not queued.
        bus.start  = 1'b1;
        bus.op     = 3'b011;
        bus.A      = 32'h8000_0001;
        bus.amount = 32'd16;
        tick();
        bus.start = 1'b0;
        edges     = 0;
        tick();
        edges++;
        bus.start  = 1'b1;
        bus.op     = 3'b010;
        bus.A      = 32'hFFFF_FFFF;
        bus.amount = 32'd1;
        tick();
        edges++;
        tick();
        edges++;
        bus.start = 1'b0;
        while (!bus.done && edges < 64) begin
            tick();
            edges++;
        end
        checkVal("midStart:doneSeen", 32'(bus.done), 32'd1);
        checkVal("midStart:latency", 32'(edges), 32'd5);
        checkVal("midStart:result", bus.result, 32'h0001_8000);
        idleCheck("midStart", 32'h0001_8000);

        // Clear in the middle of a long SHL aborts it with no done.
        bus.start  = 1'b1;
        bus.op     = 3'b010;
        bus.A      = 32'h0000_0001;
        bus.amount = 32'd31;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        checkVal("clearMid:busyBefore", 32'(bus.busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkVal("clearMid:busy", 32'(bus.busy), 32'd0);
        checkVal("clearMid:done", 32'(bus.done), 32'd0);
        checkVal("clearMid:result", bus.result, 32'd0);
        doneSeen = 0;
        repeat (12) begin
            tick();
            if (bus.done) doneSeen++;
        end
        checkVal("clearMid:noDoneAfter", 32'(doneSeen), 32'd0);
        runOp("afterClear", 3'b011, 32'h8000_0001, 32'd4, 32'h1800_0000, 2);
        idleCheck("afterClear", 32'h1800_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
